operand_fetch_stage: RTL

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/reg_scoreboard.sv | 38 +++
 rtl/operand_fetch_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I opcode constants, instruction field positions and the
// operand-usage classifier used by the operand fetch stage.
package cpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic wr_rd;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] opc, input logic [4:0] rd);
    dec_t d;
    d.uses_rs1 = 1'b1;
    d.uses_rs2 = 1'b0;
    d.wr_rd    = (rd != 5'd0);
    case (opc)
      OPC_OP: begin
        d.uses_rs2 = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        d.uses_rs2 = 1'b1;
        d.wr_rd    = 1'b0;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        d.uses_rs1 = 1'b0;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        d.uses_rs1 = 1'b1;
      end
      default: begin
        d.uses_rs1 = 1'b1;
      end
    endcase
    return d;
  endfunction

  function automatic logic wb_hit(input logic en, input logic [4:0] wb_addr,
                                  input logic [4:0] r);
    return en && (wb_addr == r) && (r != 5'd0);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, x0 never busy.
// A set in the same cycle as a clear of the same register leaves it busy.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_set_en,
  input  logic [4:0]  i_set_addr,
  input  logic        i_clr_en,
  input  logic [4:0]  i_clr_addr,
  input  logic        i_fclr_en,
  input  logic [4:0]  i_fclr_addr,
  output logic [31:0] o_busy
);

  logic [31:0] r_busy;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_busy_nxt;

  assign w_set_mask = i_set_en  ? (32'd1 << i_set_addr)  : 32'd0;
  assign w_clr_mask = (i_clr_en  ? (32'd1 << i_clr_addr)  : 32'd0)
                    | (i_fclr_en ? (32'd1 << i_fclr_addr) : 32'd0);
  assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;

  // Busy vector register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch pipeline stage: reads the register file, bypasses same-cycle
// writeback data, interlocks on busy registers and holds one issued instruction.
module operand_fetch_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [4:0]  out_rd_addr,
  output logic        out_wr_rd,
  input  logic        flush
);

  logic [6:0]  w_opc;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  dec_t        w_dec;
  logic [31:0] w_busy;
  logic        w_hit_rs1;
  logic        w_hit_rs2;
  logic        w_hit_rd;
  logic        w_hazard;
  logic        w_capture;
  logic        w_fire;
  logic        w_flush_clr;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;

  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_rs1_val;
  logic [31:0] r_out_rs2_val;
  logic [4:0]  r_out_rd_addr;
  logic        r_out_wr_rd;

  assign w_opc = in_instr[OPC_MSB:OPC_LSB];
  assign w_rd  = in_instr[RD_MSB:RD_LSB];
  assign w_rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = in_instr[RS2_MSB:RS2_LSB];
  assign w_dec = decode(w_opc, w_rd);

  assign rs1_addr = w_rs1;
  assign rs2_addr = w_rs2;

  assign w_hit_rs1 = wb_hit(wb_wr_en, wb_rd_addr, w_rs1);
  assign w_hit_rs2 = wb_hit(wb_wr_en, wb_rd_addr, w_rs2);
  assign w_hit_rd  = wb_hit(wb_wr_en, wb_rd_addr, w_rd);

  // A writeback landing this cycle releases its register, so it is not a hazard.
  assign w_hazard = (w_dec.uses_rs1 && w_busy[w_rs1] && !w_hit_rs1)
                 || (w_dec.uses_rs2 && w_busy[w_rs2] && !w_hit_rs2)
                 || (w_dec.wr_rd    && w_busy[w_rd]  && !w_hit_rd);

  assign in_ready  = (!r_out_valid || out_ready) && !w_hazard && !flush;
  assign w_capture = in_valid && in_ready;
  assign w_fire    = r_out_valid && out_ready;

  // A flushed instruction that is simultaneously firing counts as issued.
  assign w_flush_clr = flush && r_out_valid && r_out_wr_rd && !out_ready;

  assign w_rs1_val = (w_dec.uses_rs1 && (w_rs1 != 5'd0))
                   ? (w_hit_rs1 ? wb_data : rs1_data) : 32'd0;
  assign w_rs2_val = (w_dec.uses_rs2 && (w_rs2 != 5'd0))
                   ? (w_hit_rs2 ? wb_data : rs2_data) : 32'd0;

  // Output holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= 32'd0;
      r_out_instr   <= 32'd0;
      r_out_rs1_val <= 32'd0;
      r_out_rs2_val <= 32'd0;
      r_out_rd_addr <= 5'd0;
      r_out_wr_rd   <= 1'b0;
    end else if (w_capture) begin
      r_out_valid   <= 1'b1;
      r_out_pc      <= in_pc;
      r_out_instr   <= in_instr;
      r_out_rs1_val <= w_rs1_val;
      r_out_rs2_val <= w_rs2_val;
      r_out_rd_addr <= w_rd;
      r_out_wr_rd   <= w_dec.wr_rd;
    end else if (flush || w_fire) begin
      r_out_valid   <= 1'b0;
    end else begin
      r_out_valid   <= r_out_valid;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_set_en    (w_capture && w_dec.wr_rd),
    .i_set_addr  (w_rd),
    .i_clr_en    (wb_wr_en),
    .i_clr_addr  (wb_rd_addr),
    .i_fclr_en   (w_flush_clr),
    .i_fclr_addr (r_out_rd_addr),
    .o_busy      (w_busy)
  );

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_instr   = r_out_instr;
  assign out_rs1_val = r_out_rs1_val;
  assign out_rs2_val = r_out_rs2_val;
  assign out_rd_addr = r_out_rd_addr;
  assign out_wr_rd   = r_out_wr_rd;

endmodule
